// File: rtl/bnn_pkg.sv
// Shared geometry for the BNN datapath: default image/kernel sizes and the
// flat-buffer index helpers used by the engine and by the bench.
package bnn_pkg;

    localparam int IMG_W_D  = 28;
    localparam int IMG_H_D  = 28;
    localparam int K_D      = 3;
    localparam int N_FILT_D = 8;

    localparam int N_PIX   = IMG_W_D * IMG_H_D;
    localparam int N_WBITS = N_FILT_D * K_D * K_D;

    function automatic int pix_idx(input int r, input int c);
        return r * IMG_W_D + c;
    endfunction

    function automatic int w_idx(input int f, input int r, input int c);
        return f * K_D * K_D + r * K_D + c;
    endfunction

endpackage

// File: rtl/bnn_stream_fill.sv
// One valid/ready fill channel: accepts IN_W-bit beats into a DEPTH-bit buffer
// through a one-stage pipeline register and flags completion.
module bnn_stream_fill #(
    parameter int DEPTH = 784,
    parameter int IN_W  = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rearm,
    input  logic             valid,
    input  logic [IN_W-1:0]  data,
    output logic             ready,
    output logic [DEPTH-1:0] buffer,
    output logic             done
);

    localparam int BEATS = DEPTH / IN_W;
    localparam int CNT_W = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(BEATS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    if (DEPTH % IN_W != 0) begin : g_depth_check
        $error("bnn_stream_fill: DEPTH (%0d) must be a multiple of IN_W (%0d)", DEPTH, IN_W);
    end

    logic [CNT_W-1:0] acc_cnt;
    logic             pipe_valid;
    logic [IN_W-1:0]  pipe_data;
    logic [CNT_W-1:0] pipe_idx;
    logic             pipe_last;
    logic             accept;

    // Blocking ready during rearm keeps a coincident beat out of the new load.
    assign ready  = (acc_cnt != FULL) && !rearm;
    assign accept = valid && ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_cnt    <= '0;
            pipe_valid <= 1'b0;
            pipe_data  <= '0;
            pipe_idx   <= '0;
            pipe_last  <= 1'b0;
        end else if (rearm) begin
            acc_cnt    <= '0;
            pipe_valid <= 1'b0;
        end else begin
            pipe_valid <= accept;
            if (accept) begin
                pipe_data <= data;
                pipe_idx  <= acc_cnt;
                pipe_last <= (acc_cnt == LAST);
                acc_cnt   <= acc_cnt + CNT_W'(1);
            end
        end
    end

    // Rearm leaves the buffer alone; stale bits are simply overwritten later.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            buffer <= '0;
            done   <= 1'b0;
        end else if (rearm) begin
            done <= 1'b0;
        end else if (pipe_valid) begin
            buffer[int'(pipe_idx) * IN_W +: IN_W] <= pipe_data;
            if (pipe_last) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/bnn_param_loader.sv
// Loads the binary image and weight buffers for the convolution engine from
// two independent streams; start re-arms the image, and the weights on request.
module bnn_param_loader
    import bnn_pkg::*;
#(
    parameter int IMG_W  = IMG_W_D,
    parameter int IMG_H  = IMG_H_D,
    parameter int K      = K_D,
    parameter int N_FILT = N_FILT_D,
    parameter int IN_W   = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      reload_w,
    input  logic                      p_valid,
    input  logic [IN_W-1:0]           p_data,
    output logic                      p_ready,
    input  logic                      w_valid,
    input  logic [IN_W-1:0]           w_data,
    output logic                      w_ready,
    output logic [IMG_W*IMG_H-1:0]    pixels,
    output logic [N_FILT*K*K-1:0]     weights,
    output logic                      pix_done,
    output logic                      w_done,
    output logic                      load_done
);

    logic rearm_w;

    assign rearm_w   = start && reload_w;
    assign load_done = pix_done && w_done;

    bnn_stream_fill #(
        .DEPTH (IMG_W * IMG_H),
        .IN_W  (IN_W)
    ) u_pix_fill (
        .clk     (clk),
        .reset_n (reset_n),
        .rearm   (start),
        .valid   (p_valid),
        .data    (p_data),
        .ready   (p_ready),
        .buffer  (pixels),
        .done    (pix_done)
    );

    bnn_stream_fill #(
        .DEPTH (N_FILT * K * K),
        .IN_W  (IN_W)
    ) u_w_fill (
        .clk     (clk),
        .reset_n (reset_n),
        .rearm   (rearm_w),
        .valid   (w_valid),
        .data    (w_data),
        .ready   (w_ready),
        .buffer  (weights),
        .done    (w_done)
    );

endmodule

// File: tb/tb_bnn_param_loader.sv
// Directed bench for bnn_param_loader: an IN_W=1 instance for the main load,
// gap, overflow and restart cases, and an IN_W=4 instance for wide beats.
module tb_bnn_param_loader;
    import bnn_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic         reload_w;
    logic         p_valid;
    logic [0:0]   p_data;
    logic         p_ready;
    logic         w_valid;
    logic [0:0]   w_data;
    logic         w_ready;
    logic [783:0] pixels;
    logic [71:0]  weights;
    logic         pix_done;
    logic         w_done;
    logic         load_done;

    logic         reset4_n;
    logic         start4;
    logic         reload4_w;
    logic         p4_valid;
    logic [3:0]   p4_data;
    logic         p4_ready;
    logic         w4_valid;
    logic [3:0]   w4_data;
    logic         w4_ready;
    logic [783:0] pixels4;
    logic [71:0]  weights4;
    logic         pix4_done;
    logic         w4_done;
    logic         load4_done;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int pi;
    int wi;
    int first_acc_cyc;

    logic [783:0] pix_pat;
    logic [71:0]  w_pat;
    logic [783:0] exp_pix;
    localparam logic [71:0] W_A5 = 72'hA5A5A5A5A5A5A5A5A5;

    bnn_param_loader #(.IN_W(1)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .reload_w  (reload_w),
        .p_valid   (p_valid),
        .p_data    (p_data),
        .p_ready   (p_ready),
        .w_valid   (w_valid),
        .w_data    (w_data),
        .w_ready   (w_ready),
        .pixels    (pixels),
        .weights   (weights),
        .pix_done  (pix_done),
        .w_done    (w_done),
        .load_done (load_done)
    );

    bnn_param_loader #(.IN_W(4)) dut4 (
        .clk       (clk),
        .reset_n   (reset4_n),
        .start     (start4),
        .reload_w  (reload4_w),
        .p_valid   (p4_valid),
        .p_data    (p4_data),
        .p_ready   (p4_ready),
        .w_valid   (w4_valid),
        .w_data    (w4_data),
        .w_ready   (w4_ready),
        .pixels    (pixels4),
        .weights   (weights4),
        .pix_done  (pix4_done),
        .w_done    (w4_done),
        .load_done (load4_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [799:0] observed,
                               input logic [799:0] expected);
        n_checks++;
        if (observed === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drives both streams from pix_pat/w_pat until the target beat counts are accepted.
    task automatic applyStimulus(input int p_end, input int w_end, input int gap_pct,
                                 input int budget);
        bit pacc;
        bit wacc;
        int n = 0;
        first_acc_cyc = -1;
        while ((pi < p_end || wi < w_end) && n < budget) begin
            @(negedge clk);
            p_valid = (pi < p_end) && ($urandom_range(99) >= gap_pct);
            p_data  = (pi < p_end) ? pix_pat[pi] : 1'b0;
            w_valid = (wi < w_end) && ($urandom_range(99) >= gap_pct);
            w_data  = (wi < w_end) ? w_pat[wi] : 1'b0;
            #1;
            pacc = p_valid && p_ready;
            wacc = w_valid && w_ready;
            if (pacc && first_acc_cyc < 0) first_acc_cyc = cyc;
            @(posedge clk);
            if (pacc) pi++;
            if (wacc) wi++;
            n++;
        end
        @(negedge clk);
        p_valid = 1'b0;
        w_valid = 1'b0;
        checkOutput("stream_complete", (pi == p_end) && (wi == w_end), 1'b1);
    endtask

    task automatic pulse_start(input logic reload);
        @(negedge clk);
        start    = 1'b1;
        reload_w = reload;
        @(negedge clk);
        start    = 1'b0;
        reload_w = 1'b0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int done_cyc;
        int a4;
        int n;
        int c4;
        bit acc;

        reset_n  = 1'b0; start  = 1'b0; reload_w  = 1'b0;
        p_valid  = 1'b0; p_data = 1'b0; w_valid   = 1'b0; w_data  = 1'b0;
        reset4_n = 1'b0; start4 = 1'b0; reload4_w = 1'b0;
        p4_valid = 1'b0; p4_data = 4'h0; w4_valid = 1'b0; w4_data = 4'h0;

        for (int r = 0; r < IMG_H_D; r++)
            for (int c = 0; c < IMG_W_D; c++)
                pix_pat[pix_idx(r, c)] = 1'((r + c) & 1);
        w_pat = W_A5;

        repeat (3) @(negedge clk);
        reset_n  = 1'b1;
        reset4_n = 1'b1;
        @(negedge clk);

        checkOutput("reset_pixels",   pixels, '0);
        checkOutput("reset_weights",  weights, '0);
        checkOutput("reset_done",     {pix_done, w_done, load_done}, 3'b000);
        checkOutput("reset_ready",    {p_ready, w_ready}, 2'b11);

        // Full load with valid held high.
        pi = 0; wi = 0;
        applyStimulus(784, 72, 0, 3000);
        checkOutput("pix_done_not_early", pix_done, 1'b0);
        done_cyc = -1;
        for (int i = 0; i < 10; i++) begin
            if (pix_done) begin
                done_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        checkOutput("pix_done_latency", 32'(done_cyc - first_acc_cyc), 32'd785);
        checkOutput("pixel_29",   pixels[29], 1'b0);
        checkOutput("pixel_30",   pixels[30], 1'b1);
        checkOutput("pixels_full", pixels, pix_pat);
        checkOutput("weights_full", weights, W_A5);
        checkOutput("w_f0r0c0", weights[w_idx(0, 0, 0)], 1'b1);
        checkOutput("w_f7r2c2", weights[w_idx(7, 2, 2)], 1'b1);
        checkOutput("load_done_full", load_done, 1'b1);
        checkOutput("ready_low_full", {p_ready, w_ready}, 2'b00);

        // Same load after reset with random idle cycles on both streams.
        reset_dut();
        checkOutput("reset2_pixels", pixels, '0);
        pi = 0; wi = 0;
        applyStimulus(784, 72, 30, 5000);
        repeat (2) @(negedge clk);
        checkOutput("gap_pixels",    pixels, pix_pat);
        checkOutput("gap_weights",   weights, W_A5);
        checkOutput("gap_load_done", load_done, 1'b1);

        // Extra weight beats after the buffer is full.
        @(negedge clk);
        w_valid = 1'b1;
        w_data  = 1'b1;
        #1;
        checkOutput("w_ready_full", w_ready, 1'b0);
        repeat (5) @(negedge clk);
        w_valid = 1'b0;
        @(negedge clk);
        checkOutput("w_overflow_weights", weights, W_A5);
        checkOutput("w_overflow_done",    w_done, 1'b1);

        // Pixel-only re-arm followed by an all-ones image.
        pulse_start(1'b0);
        checkOutput("rearm_pix_done", pix_done, 1'b0);
        checkOutput("rearm_w_done",   w_done, 1'b1);
        checkOutput("rearm_load_done", load_done, 1'b0);
        pix_pat = '1;
        pi = 0; wi = 72;
        applyStimulus(784, 72, 0, 3000);
        repeat (2) @(negedge clk);
        checkOutput("ones_pixels",  pixels, {784{1'b1}});
        checkOutput("ones_pix_done", pix_done, 1'b1);
        checkOutput("ones_weights", weights, W_A5);
        checkOutput("ones_w_done",  w_done, 1'b1);

        // Restart at beat 100 with a beat offered in the start cycle.
        pulse_start(1'b0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            p_valid = 1'b1;
            p_data  = 1'b0;
        end
        @(negedge clk);
        start   = 1'b1;
        p_valid = 1'b1;
        p_data  = 1'b0;
        #1;
        checkOutput("start_blocks_ready", p_ready, 1'b0);
        @(negedge clk);
        start   = 1'b0;
        p_valid = 1'b1;
        p_data  = 1'b1;
        @(negedge clk);
        p_valid = 1'b0;
        repeat (2) @(negedge clk);
        exp_pix = '1;
        for (int i = 1; i <= 98; i++) exp_pix[i] = 1'b0;
        checkOutput("restart_pixels",   pixels, exp_pix);
        checkOutput("restart_pix_done", pix_done, 1'b0);

        // Wide beats on the IN_W=4 instance.
        a4 = 0; n = 0; c4 = -1;
        while (a4 < 196 && n < 1000) begin
            @(negedge clk);
            p4_valid = 1'b1;
            p4_data  = 4'b0110;
            #1;
            acc = p4_ready;
            if (acc && c4 < 0) c4 = cyc;
            @(posedge clk);
            if (acc) a4++;
            n++;
        end
        @(negedge clk);
        p4_valid = 1'b0;
        checkOutput("w4_beats", 32'(a4), 32'd196);
        done_cyc = -1;
        for (int i = 0; i < 10; i++) begin
            if (pix4_done) begin
                done_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        checkOutput("w4_pix_done_latency", 32'(done_cyc - c4), 32'd197);
        exp_pix = '0;
        for (int i = 0; i < 196; i++) begin
            exp_pix[4*i+1] = 1'b1;
            exp_pix[4*i+2] = 1'b1;
        end
        checkOutput("w4_pixels",  pixels4, exp_pix);
        checkOutput("w4_p_ready", p4_ready, 1'b0);

        // Reset in the middle of a wide load.
        @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            p4_valid = 1'b1;
            p4_data  = 4'b1111;
        end
        @(negedge clk);
        p4_valid = 1'b0;
        reset4_n = 1'b0;
        repeat (2) @(negedge clk);
        reset4_n = 1'b1;
        #1;
        checkOutput("w4_reset_pixels", pixels4, '0);
        checkOutput("w4_reset_flags",  {pix4_done, p4_ready}, 2'b01);
        @(negedge clk);
        p4_valid = 1'b1;
        p4_data  = 4'b1001;
        @(negedge clk);
        p4_valid = 1'b0;
        @(negedge clk);
        checkOutput("w4_reset_restart", pixels4, 800'h9);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bnn_param_loader.md
Name: bnn_param_loader

Overview:
Parametrised input loader for the BNN datapath. It fills a binary image buffer and a binary weight buffer from two independent streams. Each stream uses a valid/ready handshake and transfers IN_W bits per beat. The block sits between the chip input pins/pad logic and the convolution engine, and signals when both buffers are complete. A start pulse re-arms loading; a new image can be loaded while the current weights are kept.

Parameters:
IMG_W, 28, image width in pixels
IMG_H, 28, image height in pixels
K, 3, kernel edge (K x K binary kernel)
N_FILT, 8, number of filters
IN_W, 1, bits per beat on each stream; IMG_W*IMG_H and K*K*N_FILT must be multiples of IN_W (elaboration-time error otherwise)

Ports:
clk  in  1  clock
reset_n  in  1  reset, synchronous, active-low
start  in  1  single-cycle pulse; re-arms pixel loading, and weight loading when reload_w=1
reload_w  in  1  sampled with start; 1 = also reload weights, 0 = keep weights
p_valid  in  1  pixel beat valid
p_data  in  IN_W  pixel bits; bit 0 goes to the lowest index
p_ready  out  1  pixel beat accepted when p_valid && p_ready
w_valid  in  1  weight beat valid
w_data  in  IN_W  weight bits; bit 0 goes to the lowest index
w_ready  out  1  weight beat accepted when w_valid && w_ready
pixels  out  IMG_W*IMG_H  flat, row-major; pixel (r,c) at index r*IMG_W+c
weights  out  N_FILT*K*K  flat; weight (f,r,c) at index f*K*K + r*K + c
pix_done  out  1  pixel buffer complete
w_done  out  1  weight buffer complete
load_done  out  1  pix_done && w_done

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - pixels and weights go to 0.
  - Beat counters go to 0.
  - Pipeline registers are invalidated.
  - pix_done, w_done and load_done go to 0.
  - p_ready and w_ready are 1 after reset release.
- Each stream is an independent identical channel with DEPTH bits and BEATS = DEPTH/IN_W.
- Accept rules:
  - ready = (acc_cnt != BEATS) && !start. The path from start to ready is combinational.
  - On acceptance, {data, beat index, last flag} is captured into a one-stage pipeline register and acc_cnt increments.
- Write timing:
  - A beat accepted at edge t is written into the buffer at edge t+1.
  - Bits go to indices beat*IN_W .. beat*IN_W+IN_W-1, LSB first. The new values are visible after edge t+1.
- Done timing: the done flag sets at the same edge t+1 as the final beat's write. Ready drops after edge t, because acc_cnt = BEATS.
- Latency: first accepted beat to data visible is 1 cycle. For a full image at IN_W=1 with valid held high, pix_done is high IMG_W*IMG_H+1 cycles after the first beat is accepted.
- Invalid-input beats:
  - Beats offered while ready=0 are ignored.
  - valid=0 cycles stall filling with no state change. Gaps are allowed anywhere.
- start=1 with reload_w=1: both channels are re-armed.
  - At the edge, acc_cnt goes to 0, the pipeline register is invalidated (a pending write is dropped) and the done flag clears.
  - Buffer contents are not cleared; old bits remain until overwritten.
- start=1 with reload_w=0: only the pixel channel is re-armed. The weight channel, w_done and weights are unchanged, including a weight load still in progress.
- start coincident with valid: the beat is not accepted, because ready is low that cycle.
- start during an in-flight load: the load restarts from index 0 on the next accepted beat.
- Reset mid-operation: reset dominates start and all handshakes.
- load_done is combinational from the registered done flags. It stays high until start or reset.
- Counter width: $clog2(BEATS+1) bits; there is no wrap-around. Full is the terminal state until start.

Decomposition:
- Package bnn_pkg holds:
  - Defaults IMG_W_D=28, IMG_H_D=28, K_D=3, N_FILT_D=8.
  - Derived localparams N_PIX, N_WBITS.
  - Helper functions pix_idx(r,c) and w_idx(f,r,c) used by the engine and the bench.
- One sub-module, bnn_stream_fill #(DEPTH, IN_W):
  - Contains the handshake, counter, pipeline register, buffer and done flag.
  - Has a "rearm" input and is instantiated twice.
- The top level adds the start/reload_w decode and load_done.

Test Plan:
- Defaults, IN_W=1: reset; stream 784 pixels with pixel(r,c)=(r+c)&1 and 72 weights = 72'hA5A5A5A5A5A5A5A5A5, valid held high. Expected:
  - pix_done high exactly 785 cycles after the first accept.
  - pixels[29]=0 and pixels[30]=1.
  - load_done high once both streams complete.
  - Both ready signals low afterwards.
- Random valid gaps (30% idle) on both streams. Expected: final buffers identical to the previous test; no beat lost or duplicated.
- Extra beats after full (w_valid held high with data 1 after w_done). Expected: w_ready=0 and weights unchanged.
- start with reload_w=0 after load_done, then a new image of all-1 pixels. Expected:
  - pix_done drops the next cycle.
  - weights still read 72'hA5A5A5A5A5A5A5A5A5 and w_done stays 1.
  - pixels are all 1 after 784 beats.
- start pulsed at beat 100 with p_valid high in the same cycle. Expected: that beat is not accepted; the next accepted beat writes index 0; the beat accepted on the cycle before start is not written.
- IN_W=4: 196 pixel beats of 4'b0110. Expected: pixels[4n+1]=pixels[4n+2]=1 and the other bits 0; pix_done after 196 accepts plus 1 cycle. Additionally, reset asserted mid-load clears pixels to 0 and the counters to 0.
